s386_out_logger: RTL and testbench
==================================

# s386_out_logger

Downstream capture stage for the s386 controller. Samples the seven controller outputs (v13_D_12..v13_D_6) every clock, detects any change in the 7-bit vector, and queues a timestamped change record in a small FIFO. A consumer drains records over a valid/ready handshake. Overflow is counted and flagged, never silently lost.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..256.
- TS_W, 16: timestamp width in bits, 4..32.
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- en  input  1  logging enable; when low, no records are pushed.
- in_vec  input  7  controller outputs; bit 6 = v13_D_12 … bit 0 = v13_D_6.
- out_ready  input  1  consumer accepts the head record this cycle.
- clr_ovf  input  1  clears `overflow` and `drop_cnt`.
- out_valid  output  1  FIFO non-empty; head record on `out_data`.
- out_data  output  TS_W+7  {timestamp, vector}; vector in bits [6:0].
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a record is dropped.
- drop_cnt  output  8  saturating count of dropped records.

## Operation
- Registers:
  - `prev`: 7 bits.
  - `armed`: 1 bit; cleared by reset, and cleared in any cycle with en=0.
  - `ts`: free-running TS_W-bit counter; increments every cycle, wraps to 0, runs regardless of `en`.
  - FIFO storage with read/write pointers.
- Push condition at an edge: en=1 AND (armed=0 OR in_vec != prev).
  - Pushed record is {ts, in_vec}, using the pre-increment `ts` value at that edge.
  - The first record after reset or after `en` rises is unconditional. It acts as a baseline marker.
- `prev <= in_vec` every cycle, independent of `en`. `armed <= en` every cycle.
- Pop: out_valid=1 AND out_ready=1 removes the head record at the edge.
  - `out_ready` with out_valid=0 is ignored.
- Full-FIFO push rules:
  - Push with no pop: record dropped, `overflow <= 1`, `drop_cnt` increments (saturates at 255).
  - Push and pop in the same edge: both accepted, level unchanged, no drop.
- Empty-FIFO push rule: push and out_ready in the same edge pop nothing. The new record is visible the following cycle.
- clr_ovf=1 clears `overflow` and `drop_cnt`. If a drop happens in the same edge, the drop wins: overflow=1, drop_cnt=1.
- `out_data` is the head entry when out_valid=1. It is don't-care when out_valid=0.
- Reset values: out_valid=0, level=0, overflow=0, drop_cnt=0, ts=0, prev=0, armed=0, pointers=0. FIFO contents are not reset.
- RST mid-operation discards all queued records at that edge. Reset has priority over push, pop and clear.

## Timing
- Change on in_vec settled before edge t → record written at edge t → out_valid=1 in cycle t+1 if the FIFO was empty.
- Timestamps of consecutive records differ by the number of cycles between their push edges, modulo 2^TS_W.
- Throughput: one push and one pop per cycle sustained; a vector changing every cycle with out_ready=1 never drops.
- level updates at the edge: +1 on push only, −1 on pop only, unchanged on both or neither.
- No combinational path from in_vec to any output. out_valid and level are registered or derived from pointers only.

## Test plan
- Reset, then en=1 with in_vec=7'h00 held → one baseline record {ts=1, 7'h00} (ts=0 at the reset edge), then no further records. level=1, out_valid=1.
- With out_ready=0, change in_vec 7'h00→7'h41→7'h41→7'h02 on consecutive cycles → exactly two records, vectors 7'h41 and 7'h02, timestamps differing by 2.
- DEPTH=8, out_ready=0, toggle in_vec every cycle for 12 cycles after baseline:
  - 8 records kept, 5 dropped; overflow=1, drop_cnt=5.
  - Then clr_ovf pulse → overflow=0, drop_cnt=0, level stays 8.
- FIFO full with out_ready=1 and a change in the same cycle → level stays 8, drop_cnt unchanged, head advances.
- en low for 3 cycles while in_vec changes → no records. en high → fresh baseline record of the current vector.
- RST asserted with level=5 → next cycle out_valid=0, level=0, ts=0.
- Let ts wrap at TS_W=4 → timestamp sequence …,14,15,0,1 is logged correctly.

Source files
------------

// File: rtl/s386_out_logger.sv
// s386_out_logger
// Capture stage for the s386 controller outputs. The 7-bit vector is sampled
// every clock. A timestamped record {ts, vector} is queued whenever the vector
// changes, or unconditionally on the first enabled cycle as a baseline marker.
// A consumer drains the queue over a valid/ready handshake. A record that finds
// the queue full, with no pop in the same cycle, is dropped and counted.
//
// Ports
//   CK         clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   en         logging enable; no records are pushed while low
//   in_vec     controller outputs, bit 6 = v13_D_12 ... bit 0 = v13_D_6
//   out_ready  consumer accepts the head record this cycle
//   clr_ovf    clears overflow and drop_cnt
//   out_valid  queue non-empty, head record on out_data
//   out_data   head record {timestamp, vector}, vector in bits [6:0]
//   level      current queue occupancy
//   overflow   sticky flag, set when a record is dropped
//   drop_cnt   saturating count of dropped records
module s386_out_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                     CK,
  input  logic                     RST,
  input  logic                     en,
  input  logic [6:0]               in_vec,
  input  logic                     out_ready,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  output logic [TS_W+6:0]          out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_W + 7;

  logic [6:0]    prev;
  logic          armed;
  logic [TS_W-1:0] ts;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [RW-1:0] mem [DEPTH];

  logic want_push;
  logic do_pop;
  logic do_push;
  logic drop;
  logic full;

  // A disarmed logger (after reset or while en is low) forces a baseline record.
  assign want_push = en && (!armed || (in_vec != prev));
  assign full      = (level == (AW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign do_pop    = out_valid && out_ready;
  // A pop in the same edge frees the slot, so a full queue still accepts.
  assign do_push   = want_push && (!full || do_pop);
  assign drop      = want_push && full && !do_pop;
  assign out_data  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge CK) begin
    if (RST) begin
      prev     <= '0;
      armed    <= 1'b0;
      ts       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      prev  <= in_vec;
      armed <= en;
      ts    <= ts + 1'b1;

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // A drop in the same edge as a clear wins; the clear is then applied
      // before counting, leaving exactly one drop on record.
      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf)               drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  // NOTE: the storage array is deliberately left out of reset; validity is
  // tracked by the pointers and level, so stale contents are never observed.
  always_ff @(posedge CK) begin
    if (!RST && do_push) mem[wr_ptr] <= {ts, in_vec};
  end

endmodule

// File: tb/tb_s386_out_logger.sv
// Directed bench for s386_out_logger with DEPTH=8 and TS_W=4, so timestamp
// wrap-around is exercised by the overflow/drain sequence. Inputs are driven
// 1 time unit after each rising edge and outputs are checked there as well.
module tb_s386_out_logger;

  localparam int DEPTH = 8;
  localparam int TS_W  = 4;

  logic        CK = 1'b0;
  logic        RST;
  logic        en;
  logic [6:0]  in_vec;
  logic        out_ready;
  logic        clr_ovf;
  logic        out_valid;
  logic [10:0] out_data;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  s386_out_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .CK        (CK),
    .RST       (RST),
    .en        (en),
    .in_vec    (in_vec),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  function automatic logic [10:0] rec(input int t, input logic [6:0] v);
    logic [3:0] t4;
    t4 = t[3:0];
    return {t4, v};
  endfunction

  logic [10:0] drain_exp [8];

  initial begin
    RST = 1'b1; en = 1'b0; in_vec = 7'h00; out_ready = 1'b0; clr_ovf = 1'b0;
    step();
    step();                                   // E0: last reset edge, ts=0
    check("rst_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_drop",  32'(drop_cnt), 0);

    // Baseline record
    RST = 1'b0;
    step();                                   // E1, ts -> 1
    check("pre_en_level", 32'(level), 0);
    en = 1'b1;
    step();                                   // E2 pushes {1,00}
    check("base_level", 32'(level), 1);
    check("base_valid", 32'(out_valid), 1);
    check("base_data",  32'(out_data), 32'(rec(1, 7'h00)));
    step(); step();                           // E3,E4 no change
    check("hold_level", 32'(level), 1);

    // Change detection: 00 -> 41 -> 41 -> 02
    in_vec = 7'h41; step();                   // E5 push {4,41}
    in_vec = 7'h41; step();                   // E6 none
    in_vec = 7'h02; step();                   // E7 push {6,02}
    check("chg_level", 32'(level), 3);
    out_ready = 1'b1;
    check("pop0", 32'(out_data), 32'(rec(1, 7'h00)));
    step();                                   // E8
    check("pop1", 32'(out_data), 32'(rec(4, 7'h41)));
    step();                                   // E9
    check("pop2", 32'(out_data), 32'(rec(6, 7'h02)));
    step();                                   // E10
    check("pop_empty_valid", 32'(out_valid), 0);
    check("pop_empty_level", 32'(level), 0);
    out_ready = 1'b0;

    // Overflow: fresh baseline then 12 toggles
    en = 1'b0; step();                        // E11 disarm
    en = 1'b1; step();                        // E12 baseline {11,02}
    for (int i = 0; i < 12; i++) begin        // E13..E24
      in_vec = (i % 2 == 0) ? 7'h55 : 7'h2A;
      step();
    end
    check("ovf_level", 32'(level), 8);
    check("ovf_flag",  32'(overflow), 1);
    check("ovf_drop",  32'(drop_cnt), 5);
    clr_ovf = 1'b1; step();                   // E25 clear, in_vec held 2A
    check("clr_flag",  32'(overflow), 0);
    check("clr_drop",  32'(drop_cnt), 0);
    check("clr_level", 32'(level), 8);

    // Clear and drop on the same edge: drop wins
    in_vec = 7'h55; step();                   // E26 drop + clr
    check("clrdrop_flag", 32'(overflow), 1);
    check("clrdrop_cnt",  32'(drop_cnt), 1);
    clr_ovf = 1'b0; step();                   // E27 no change

    // Full queue, push and pop on the same edge
    check("full_head", 32'(out_data), 32'(rec(11, 7'h02)));
    out_ready = 1'b1; in_vec = 7'h2A; step(); // E28 pop + push {27->11,2A}
    check("pp_level", 32'(level), 8);
    check("pp_drop",  32'(drop_cnt), 1);

    // Drain; covers timestamp wrap 14,15,0,1
    drain_exp[0] = rec(12, 7'h55);
    drain_exp[1] = rec(13, 7'h2A);
    drain_exp[2] = rec(14, 7'h55);
    drain_exp[3] = rec(15, 7'h2A);
    drain_exp[4] = rec(0,  7'h55);
    drain_exp[5] = rec(1,  7'h2A);
    drain_exp[6] = rec(2,  7'h55);
    drain_exp[7] = rec(11, 7'h2A);
    for (int i = 0; i < 8; i++) begin         // E29..E36
      check($sformatf("drain%0d", i), 32'(out_data), 32'(drain_exp[i]));
      step();
    end
    check("drain_level", 32'(level), 0);
    out_ready = 1'b0;

    // en low while vector changes
    en = 1'b0;
    in_vec = 7'h11; step();                   // E37
    in_vec = 7'h22; step();                   // E38
    in_vec = 7'h33; step();                   // E39
    check("en_low_level", 32'(level), 0);
    en = 1'b1; out_ready = 1'b1; step();      // E40 baseline {7,33}, ready ignored
    check("rearm_level", 32'(level), 1);
    check("rearm_data",  32'(out_data), 32'(rec(7, 7'h33)));
    step();                                   // E41 pop
    check("rearm_pop", 32'(level), 0);
    out_ready = 1'b0;

    // Reset with five queued records
    for (int i = 1; i <= 5; i++) begin        // E42..E46
      in_vec = 7'(i);
      step();
    end
    check("pre_rst_level", 32'(level), 5);
    RST = 1'b1; step();                       // E47
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_drop",  32'(drop_cnt), 0);
    RST = 1'b0; step();                       // E48 baseline with ts=0
    check("post_rst_data", 32'(out_data), 32'(rec(0, 7'h05)));
    check("post_rst_level", 32'(level), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
